// File: rtl/logs_iterate_map_mc.sv
// Multi-channel logistic-map iterator: x <- r*x*(1-x) per channel, time-multiplexed
// over one shared shift-and-add multiplier with a fixed TDM slot per channel.
`timescale 1ns/1ps
module logs_iterate_map_mc #(
  parameter int              FRAC      = 8,
  parameter int              CHANNELS  = 4,
  parameter int              ITER_LEN  = 0,
  parameter logic [FRAC-1:0] INITIAL_X = FRAC'(1 << (FRAC-4)),
  localparam int             CW        = $clog2(CHANNELS)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            run,
  input  logic            cfg_we,
  input  logic [CW-1:0]   cfg_ch,
  input  logic [FRAC+1:0] cfg_r,
  input  logic [FRAC-1:0] cfg_x,
  input  logic            cfg_en,
  input  logic [CW-1:0]   rd_ch,
  output logic [FRAC-1:0] rd_x,
  output logic            out_valid,
  output logic [CW-1:0]   out_ch,
  output logic [FRAC-1:0] out_x,
  output logic            busy
);

  localparam int SLOT_LEN = (ITER_LEN > 2*FRAC+3) ? ITER_LEN : 2*FRAC+3;
  localparam int CNT_W    = $clog2(SLOT_LEN);
  localparam int AW       = 2*FRAC+2;

  localparam logic [CNT_W-1:0] C_MUL1_LAST = CNT_W'(FRAC);
  localparam logic [CNT_W-1:0] C_LOAD2     = CNT_W'(FRAC+1);
  localparam logic [CNT_W-1:0] C_MUL2_LAST = CNT_W'(2*FRAC+1);
  localparam logic [CNT_W-1:0] C_WB        = CNT_W'(2*FRAC+2);
  localparam logic [CNT_W-1:0] C_LAST      = CNT_W'(SLOT_LEN-1);
  localparam logic [CW-1:0]    LAST_CH     = CW'(CHANNELS-1);

  logic [FRAC+1:0] r_q  [CHANNELS];
  logic [FRAC-1:0] x_q  [CHANNELS];
  logic            en_q [CHANNELS];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    m1_q, m1_d;
  logic [FRAC-1:0]  m2_q, m2_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic             inval_q, inval_d;
  logic             out_valid_q;
  logic [CW-1:0]    out_ch_q;
  logic [FRAC-1:0]  out_x_q;

  logic            cfg_hit;
  logic            wb_fire;
  logic [FRAC-1:0] xn;

  // NOTE: every variable gets a default before any branch so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    acc_d   = acc_q;
    inval_d = inval_q;
    wb_fire = 1'b0;
    xn      = acc_q[2*FRAC-1:FRAC];
    cfg_hit = cfg_we && (cfg_ch == ptr_q);

    if (cnt_q == '0) begin
      if (run) begin
        m1_d    = AW'(x_q[ptr_q]);
        m2_d    = ~x_q[ptr_q];
        acc_d   = '0;
        inval_d = 1'b0;
        cnt_d   = CNT_W'(1);
      end
    end else begin
      if ((cnt_q <= C_MUL1_LAST) || ((cnt_q > C_LOAD2) && (cnt_q <= C_MUL2_LAST))) begin
        if (m2_q[0]) acc_d = acc_q + m1_q;
        m1_d = m1_q << 1;
        m2_d = m2_q >> 1;
      end else if (cnt_q == C_LOAD2) begin
        m1_d  = AW'(r_q[ptr_q]);
        m2_d  = acc_q[2*FRAC-1:FRAC];
        acc_d = '0;
      end else if (cnt_q == C_WB) begin
        // A same-channel write on this very edge beats the computed result.
        wb_fire = en_q[ptr_q] && !inval_q && !cfg_hit;
      end

      if (cfg_hit && (cnt_q <= C_WB)) inval_d = 1'b1;

      if (cnt_q == C_LAST) begin
        cnt_d = '0;
        ptr_d = (ptr_q == LAST_CH) ? '0 : ptr_q + CW'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      ptr_q       <= '0;
      m1_q        <= '0;
      m2_q        <= '0;
      acc_q       <= '0;
      inval_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_x_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      m1_q        <= m1_d;
      m2_q        <= m2_d;
      acc_q       <= acc_d;
      inval_q     <= inval_d;
      out_valid_q <= wb_fire;
      if (wb_fire) begin
        out_ch_q <= ptr_q;
        out_x_q  <= xn;
      end
    end
  end

  // NOTE: the per-channel arrays are reset because software relies on known
  // r/x/en values straight out of reset; they are small register files, not RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_q[i]  <= '0;
        x_q[i]  <= INITIAL_X;
        en_q[i] <= 1'b0;
      end
    end else begin
      if (wb_fire) x_q[ptr_q] <= xn;
      if (cfg_we) begin
        r_q[cfg_ch]  <= cfg_r;
        x_q[cfg_ch]  <= cfg_x;
        en_q[cfg_ch] <= cfg_en;
      end
    end
  end

  assign rd_x      = x_q[rd_ch];
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_x     = out_x_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_logs_iterate_map_mc.sv
// Directed bench for logs_iterate_map_mc (FRAC=8, CHANNELS=4, SLOT_LEN=19):
// vector table for single iterations plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_logs_iterate_map_mc;

  logic       clk;
  logic       reset_n;
  logic       run;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [9:0] cfg_r;
  logic [7:0] cfg_x;
  logic       cfg_en;
  logic [1:0] rd_ch;
  logic [7:0] rd_x;
  logic       out_valid;
  logic [1:0] out_ch;
  logic [7:0] out_x;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  logs_iterate_map_mc dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (run),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_r     (cfg_r),
    .cfg_x     (cfg_x),
    .cfg_en    (cfg_en),
    .rd_ch     (rd_ch),
    .rd_x      (rd_x),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_x     (out_x),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] r;
    logic [7:0] x;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [9:0] r,
                           input logic [7:0] x, input logic en);
    cfg_we = 1'b1; cfg_ch = ch; cfg_r = r; cfg_x = x; cfg_en = en;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_strobe(input int max_cyc, output bit found, output int n);
    found = 1'b0;
    n     = 0;
    while (!found && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) found = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; run = 1'b0; cfg_we = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  // Golden model: arithmetic on integers, floor truncation, one's complement for 1-x.
  function automatic logic [7:0] model_step(input logic [9:0] r, input logic [7:0] x);
    int xi, nxi, t, y;
    xi  = int'(x);
    nxi = 255 - xi;
    t   = (xi * nxi) / 256;
    y   = (int'(r) * t) / 256;
    return y[7:0];
  endfunction

  initial begin
    bit         found;
    int         n;
    bit         saw;
    logic [7:0] mx [4];
    logic [7:0] exp_x3 [3];

    vecs[0] = '{r: 10'h200, x: 8'h80, exp: 8'h7E};
    vecs[1] = '{r: 10'h3FF, x: 8'h80, exp: 8'hFB};
    vecs[2] = '{r: 10'h000, x: 8'h80, exp: 8'h00};
    vecs[3] = '{r: 10'h3FF, x: 8'h00, exp: 8'h00};
    vecs[4] = '{r: 10'h3FF, x: 8'hFF, exp: 8'h00};
    vecs[5] = '{r: 10'h100, x: 8'h40, exp: 8'h2F};
    vecs[6] = '{r: 10'h3C0, x: 8'h10, exp: 8'h34};
    vecs[7] = '{r: 10'h2AB, x: 8'hC3, exp: 8'h78};
    vecs[8] = '{r: 10'h3FF, x: 8'h7F, exp: 8'hFB};

    cfg_ch = '0; cfg_r = '0; cfg_x = '0; cfg_en = 1'b0; rd_ch = '0;
    do_reset();

    // Reset state
    for (int c = 0; c < 4; c++) begin
      rd_ch = 2'(c);
      #1;
      check($sformatf("reset_rd_x_ch%0d", c), 32'(rd_x), 32'h10);
    end
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_out_ch",    32'(out_ch),    0);
    check("reset_out_x",     32'(out_x),     0);
    check("reset_busy",      32'(busy),      0);

    // Single channel: strobe after the 19th edge
    cfg_write(2'd0, 10'h200, 8'h80, 1'b1);
    run = 1'b1;
    tick(1);
    check("single_busy_after_start", 32'(busy), 1);
    check("single_no_early_valid", 32'(out_valid), 0);
    wait_strobe(60, found, n);
    check("single_found", 32'(found), 1);
    check("single_edge_count", 32'(n + 1), 19);
    check("single_out_ch", 32'(out_ch), 0);
    check("single_out_x", 32'(out_x), 32'h7E);
    rd_ch = 2'd0;
    #0;
    check("single_rd_x", 32'(rd_x), 32'h7E);
    check("single_busy_slot_end", 32'(busy), 0);
    tick(1);
    check("single_valid_one_cycle", 32'(out_valid), 0);
    check("single_out_x_hold", 32'(out_x), 32'h7E);

    // Table: reseed ch0 while another channel's slot runs, check next ch0 result
    for (int i = 0; i < 9; i++) begin
      cfg_write(2'd0, vecs[i].r, vecs[i].x, 1'b1);
      wait_strobe(100, found, n);
      check($sformatf("vec%0d_found", i), 32'(found), 1);
      check($sformatf("vec%0d_out_ch", i), 32'(out_ch), 0);
      check($sformatf("vec%0d_out_x", i), 32'(out_x), 32'(vecs[i].exp));
    end
    run = 1'b0;

    // Skip: only ch2 enabled; first strobe after edge 57
    do_reset();
    cfg_write(2'd2, 10'h3FF, 8'h80, 1'b1);
    run = 1'b1;
    wait_strobe(200, found, n);
    check("skip_found", 32'(found), 1);
    check("skip_edge_count", 32'(n), 57);
    check("skip_out_ch", 32'(out_ch), 2);
    check("skip_out_x", 32'(out_x), 32'hFB);

    // Asynchronous reset at cnt = 10 clears outputs before any edge
    tick(10);
    check("pre_areset_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("areset_busy", 32'(busy), 0);
    check("areset_out_valid", 32'(out_valid), 0);
    check("areset_out_ch", 32'(out_ch), 0);
    check("areset_out_x", 32'(out_x), 0);
    rd_ch = 2'd2;
    #1;
    check("areset_rd_x_ch2", 32'(rd_x), 32'h10);

    // Invalidate: write ch0 at cnt = 5 of its own slot
    do_reset();
    cfg_write(2'd0, 10'h200, 8'h80, 1'b1);
    run = 1'b1;
    tick(5);
    cfg_write(2'd0, 10'h200, 8'h40, 1'b1);
    saw = 1'b0;
    for (int k = 0; k < 13; k++) begin
      tick(1);
      if (out_valid) saw = 1'b1;
    end
    check("inval_no_strobe", 32'(saw), 0);
    rd_ch = 2'd0;
    #0;
    check("inval_rd_x_ch0", 32'(rd_x), 32'h40);
    // Next ch0 slot: a write to ch1 at cnt = 5 must not disturb it
    tick(62);
    cfg_write(2'd1, 10'h100, 8'h55, 1'b0);
    wait_strobe(30, found, n);
    check("other_found", 32'(found), 1);
    check("other_edge_count", 32'(n), 13);
    check("other_out_ch", 32'(out_ch), 0);
    check("other_out_x", 32'(out_x), 32'h5E);
    rd_ch = 2'd1;
    #0;
    check("other_rd_x_ch1", 32'(rd_x), 32'h55);
    run = 1'b0;

    // Run stop and wrap
    do_reset();
    cfg_write(2'd0, 10'h200, 8'h80, 1'b1);
    cfg_write(2'd1, 10'h3FF, 8'h80, 1'b1);
    cfg_write(2'd2, 10'h100, 8'h40, 1'b1);
    cfg_write(2'd3, 10'h3C0, 8'h10, 1'b1);
    exp_x3[0] = 8'h7E; exp_x3[1] = 8'hFB; exp_x3[2] = 8'h2F;
    run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_strobe(30, found, n);
      check($sformatf("wrap_ch%0d_found", k), 32'(found), 1);
      check($sformatf("wrap_ch%0d_edges", k), 32'(n), 19);
      check($sformatf("wrap_ch%0d_out_ch", k), 32'(out_ch), 32'(k));
      check($sformatf("wrap_ch%0d_out_x", k), 32'(out_x), 32'(exp_x3[k]));
    end
    tick(3);
    run = 1'b0;
    wait_strobe(30, found, n);
    check("stop_ch3_found", 32'(found), 1);
    check("stop_ch3_edges", 32'(n), 16);
    check("stop_ch3_out_ch", 32'(out_ch), 3);
    check("stop_ch3_out_x", 32'(out_x), 32'h34);
    check("stop_busy_low", 32'(busy), 0);
    saw = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      if (out_valid || busy) saw = 1'b1;
    end
    check("stop_stays_idle", 32'(saw), 0);
    run = 1'b1;
    wait_strobe(30, found, n);
    check("restart_found", 32'(found), 1);
    check("restart_edges", 32'(n), 19);
    check("restart_out_ch", 32'(out_ch), 0);
    check("restart_out_x", 32'(out_x), 32'h7E);
    run = 1'b0;

    // Long run: 1000 iterations with r = 0x3C0 across all channels
    do_reset();
    mx[0] = 8'h80; mx[1] = 8'h33; mx[2] = 8'hA5; mx[3] = 8'h1F;
    for (int c = 0; c < 4; c++) cfg_write(2'(c), 10'h3C0, mx[c], 1'b1);
    run = 1'b1;
    for (int it = 0; it < 1000; it++) begin
      int c;
      int err_before;
      c = it % 4;
      err_before = n_err;
      mx[c] = model_step(10'h3C0, mx[c]);
      wait_strobe(25, found, n);
      check($sformatf("long%0d_found", it), 32'(found), 1);
      check($sformatf("long%0d_out_ch", it), 32'(out_ch), 32'(c));
      check($sformatf("long%0d_out_x", it), 32'(out_x), 32'(mx[c]));
      if (n_err != err_before) break;
    end
    run = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
